// File: rtl/picorv32_sram_responder_pkg.sv
// ============================================================================
// Module      : picorv32_sram_pkg
// Description : Shared types and constants for the picorv32 SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package picorv32_sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int SRAM_DW = 32;
    localparam int SRAM_MW = 4;

    // Geometry of the default sky130 OpenRAM macro (32 x 512, 1rw port used)
    localparam int SKY130_SRAM_WORDS   = 512;
    localparam int SKY130_SRAM_AW      = 9;
    localparam int SKY130_SRAM_LATENCY = 1;

endpackage

`default_nettype wire

// File: rtl/picorv32_sram_responder_if.sv
// ============================================================================
// Module      : picorv32_sram_responder_if
// Description : picorv32 native memory bus (valid/ready) with error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface picorv32_sram_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, err
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, err
    );
endinterface

`default_nettype wire

// File: rtl/picorv32_sram_responder_decode.sv
// ============================================================================
// Module      : picorv32_sram_decode
// Description : Byte address to SRAM word index and window range check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module picorv32_sram_decode #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MEM_WORDS = 512,
    parameter int          SRAM_AW   = 9
) (
    input  wire logic [31:0]        i_mem_addr,
    output logic                    o_in_range,
    output logic [SRAM_AW-1:0]      o_word_idx
);
    localparam logic [31:0] c_WINDOW_BYTES = 32'(MEM_WORDS) << 2;

    logic [31:0] w_off;
    logic        w_unused_off;

    // The explicit lower-bound test prevents wrapped offsets aliasing into the window
    assign w_off        = i_mem_addr - ADDR_BASE;
    assign o_in_range   = (i_mem_addr >= ADDR_BASE) && (w_off < c_WINDOW_BYTES);
    assign o_word_idx   = w_off[SRAM_AW+1:2];
    assign w_unused_off = ^{w_off[1:0], w_off[31:SRAM_AW+2]};
endmodule

`default_nettype wire

// File: rtl/picorv32_sram_responder.sv
// ============================================================================
// Module      : picorv32_sram_responder
// Description : picorv32 memory-bus responder driving one sky130 SRAM port.
//               Optional access counters enabled by SRAM_RESP_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module picorv32_sram_responder
    import picorv32_sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int          MEM_WORDS    = SKY130_SRAM_WORDS,
    parameter int          SRAM_AW      = SKY130_SRAM_AW,
    parameter int          READ_LATENCY = SKY130_SRAM_LATENCY,
    parameter int          WAIT_STATES  = 0
) (
    input  wire logic                   clk,
    input  wire logic                   resetn,
    picorv32_sram_responder_if.slave    bus,
    output logic                        sram_csb,
    output logic                        sram_web,
    output logic [SRAM_MW-1:0]          sram_wmask,
    output logic [SRAM_AW-1:0]          sram_addr,
    output logic [SRAM_DW-1:0]          sram_din,
    input  wire logic [SRAM_DW-1:0]     sram_dout,
    output logic [31:0]                 rd_count,
    output logic [31:0]                 wr_count
);
    localparam int c_CNT_MAX = WAIT_STATES + READ_LATENCY - 1;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_WR = c_CNT_W'(WAIT_STATES);
    localparam logic [c_CNT_W-1:0] c_CNT_RD = c_CNT_W'(c_CNT_MAX);

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_err, w_err_nxt;
    logic [SRAM_DW-1:0]   r_rdata, w_rdata_nxt;
    logic                 r_csb, w_csb_nxt;
    logic                 r_web, w_web_nxt;
    logic [SRAM_MW-1:0]   r_wmask, w_wmask_nxt;
    logic [SRAM_AW-1:0]   r_addr, w_addr_nxt;
    logic [SRAM_DW-1:0]   r_din, w_din_nxt;
    logic                 r_is_read, w_is_read_nxt;
    logic                 w_in_range;
    logic [SRAM_AW-1:0]   w_word_idx;
    logic                 w_unused;

    assign w_unused = bus.mem_instr;

    picorv32_sram_decode #(
        .ADDR_BASE (ADDR_BASE),
        .MEM_WORDS (MEM_WORDS),
        .SRAM_AW   (SRAM_AW)
    ) u_decode (
        .i_mem_addr (bus.mem_addr),
        .o_in_range (w_in_range),
        .o_word_idx (w_word_idx)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_csb     <= 1'b1;
            r_web     <= 1'b1;
            r_wmask   <= '0;
            r_addr    <= '0;
            r_din     <= '0;
            r_is_read <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ready   <= w_ready_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata_nxt;
            r_csb     <= w_csb_nxt;
            r_web     <= w_web_nxt;
            r_wmask   <= w_wmask_nxt;
            r_addr    <= w_addr_nxt;
            r_din     <= w_din_nxt;
            r_is_read <= w_is_read_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ready_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = r_rdata;
        w_csb_nxt     = r_csb;
        w_web_nxt     = r_web;
        w_wmask_nxt   = r_wmask;
        w_addr_nxt    = r_addr;
        w_din_nxt     = r_din;
        w_is_read_nxt = r_is_read;
        unique case (r_state)
            IDLE: begin
                if (bus.mem_valid) begin
                    if (w_in_range) begin
                        w_addr_nxt    = w_word_idx;
                        w_din_nxt     = bus.mem_wdata;
                        w_wmask_nxt   = bus.mem_wstrb;
                        w_web_nxt     = (bus.mem_wstrb == 4'b0000);
                        w_is_read_nxt = (bus.mem_wstrb == 4'b0000);
                        w_csb_nxt     = 1'b0;
                        w_state_nxt   = ISSUE;
                    end else begin
                        w_ready_nxt   = 1'b1;
                        w_err_nxt     = 1'b1;
                        w_rdata_nxt   = '0;
                        w_state_nxt   = RESP;
                    end
                end
            end
            ISSUE: begin
                // The macro captures on the edge that ends this cycle
                w_csb_nxt   = 1'b1;
                w_web_nxt   = 1'b1;
                w_wmask_nxt = '0;
                w_cnt_nxt   = r_is_read ? c_CNT_RD : c_CNT_WR;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end else begin
                    w_ready_nxt = 1'b1;
                    if (r_is_read) begin
                        w_rdata_nxt = sram_dout;
                    end
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mem_ready = r_ready;
    assign bus.mem_rdata = r_rdata;
    assign bus.err       = r_err;
    assign sram_csb      = r_csb;
    assign sram_web      = r_web;
    assign sram_wmask    = r_wmask;
    assign sram_addr     = r_addr;
    assign sram_din      = r_din;

`ifdef SRAM_RESP_PERF_EN
    logic [31:0] r_rd_count, r_wr_count;
    logic        w_done;

    assign w_done = (r_state == WAIT) && (r_cnt == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_done) begin
            if (r_is_read && (r_rd_count != 32'hFFFF_FFFF)) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (!r_is_read && (r_wr_count != 32'hFFFF_FFFF)) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif
endmodule

`default_nettype wire

// File: doc/picorv32_sram_responder.md
Name: picorv32_sram_responder

Overview:
- Responder (slave) end of the picorv32 native memory interface (mem_valid/mem_ready handshake).
- Decodes the byte address into a word index, sequences one access on a single-port sky130 OpenRAM macro port, waits the macro read latency plus configurable wait states, then returns registered mem_rdata with a one-cycle mem_ready.
- Out-of-range accesses complete immediately with an error pulse and no SRAM activity.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte base address of the SRAM window.
- MEM_WORDS, 512, number of 32-bit words behind the window.
- SRAM_AW, 9, SRAM word-address width; must satisfy 2**SRAM_AW >= MEM_WORDS.
- READ_LATENCY, 1, clock edges from SRAM capture edge to dout valid (>=1).
- WAIT_STATES, 0, extra cycles added to every in-range access (0..15).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- mem_valid  in  1  request valid from core.
- mem_instr  in  1  request is an instruction fetch.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 0 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  registered read data; valid while mem_ready=1.
- err  out  1  one-cycle pulse, coincident with mem_ready, on an out-of-range access.
- sram_csb  out  1  macro chip select, active-low.
- sram_web  out  1  macro write enable, active-low.
- sram_wmask  out  4  macro byte write mask.
- sram_addr  out  SRAM_AW  macro word address.
- sram_din  out  32  macro write data.
- sram_dout  in  32  macro read data.
- rd_count  out  32  completed in-range reads (see Optional Feature).
- wr_count  out  32  completed in-range writes (see Optional Feature).

Behaviour:
- Reset (async, resetn=0): state IDLE, counter 0; mem_ready=0, mem_rdata=0, err=0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0, rd_count=wr_count=0.
- All outputs are registered.
- Decode:
  - off = mem_addr - ADDR_BASE (32-bit unsigned).
  - in_range = (mem_addr >= ADDR_BASE) && (off < MEM_WORDS*4).
  - word index = off[SRAM_AW+1:2]; mem_addr[1:0] is ignored.
- IDLE, mem_valid=1, in_range:
  - Load sram_addr, sram_din=mem_wdata, sram_wmask=mem_wstrb, sram_web=(mem_wstrb==0), sram_csb=0.
  - Go to ISSUE.
- IDLE, mem_valid=1, !in_range:
  - mem_ready=1, err=1, mem_rdata=0, no SRAM access.
  - Go to RESP.
- ISSUE (one cycle; the macro captures at its end):
  - sram_csb=1, sram_web=1, sram_wmask=0.
  - Load counter = WAIT_STATES + (read ? READ_LATENCY-1 : 0).
  - Go to WAIT.
- WAIT:
  - If counter != 0: decrement.
  - Else: mem_ready=1; for reads, mem_rdata<=sram_dout. Go to RESP.
- RESP (mem_ready and err high this cycle only):
  - Clear mem_ready and err; go to IDLE.
  - The initiator must drop or change mem_valid at the handshake edge; IDLE re-samples mem_valid in the cycle after RESP.
- Latency, with mem_valid first high in cycle 0:
  - In-range read: mem_ready in cycle 3+WAIT_STATES+(READ_LATENCY-1).
  - In-range write: mem_ready in cycle 3+WAIT_STATES.
  - Out-of-range: mem_ready in cycle 1.
- Boundary behaviour:
  - Request inputs are ignored outside IDLE; the request is latched at the IDLE edge.
  - mem_wstrb values such as 4'b0101 are passed to sram_wmask verbatim.
  - mem_rdata holds its value between accesses; it is not cleared on writes.
  - Address just past the window (ADDR_BASE + MEM_WORDS*4) is out of range.
  - mem_addr below ADDR_BASE is out of range; there is no wrap-around aliasing.
  - Reset mid-access aborts immediately; SRAM content at an in-flight write address is undefined.
- mem_instr does not affect timing.

Optional Feature:
- Macro SRAM_RESP_PERF_EN.
- Defined:
  - rd_count increments at each in-range read completion; wr_count increments at each in-range write completion.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: rd_count and wr_count are tied to 0 and no counter flops exist.

Decomposition:
- Package picorv32_sram_pkg:
  - state typedef {IDLE, ISSUE, WAIT, RESP}.
  - SRAM_DW=32, SRAM_MW=4.
  - Default sky130 macro geometry constants.
- One combinational sub-module, picorv32_sram_decode: mem_addr -> in_range and word index, parameterised by ADDR_BASE, MEM_WORDS, SRAM_AW.
- FSM and counter stay in the top module.

Test Plan:
- Write 32'hCAFEBABE at 0x0000_0010, wstrb=4'hF, then read 0x10 -> sram_addr=4 during ISSUE; write mem_ready in cycle 3; read mem_ready in cycle 3 with mem_rdata=32'hCAFEBABE (READ_LATENCY=1, WAIT_STATES=0).
- Byte write 32'h000000AA, wstrb=4'b0001, at 0x10 over 32'hCAFEBABE -> sram_wmask=4'b0001; read back 32'hCAFEBAAA.
- Read at 0x0000_0800 (MEM_WORDS=512) -> mem_ready and err in cycle 1, mem_rdata=0, sram_csb never low.
- WAIT_STATES=3, READ_LATENCY=2 read -> mem_ready in cycle 7, and a back-to-back write issued right after -> mem_ready 6 cycles after that write's valid.
- Assert resetn=0 during WAIT of a read -> all outputs at reset values asynchronously; after release, a fresh read of 0x10 completes normally.
- SRAM_RESP_PERF_EN defined: 3 reads, 2 writes, 1 out-of-range access -> rd_count=3, wr_count=2; without the macro both read 0.
